// File: rtl/bus_arb.sv
// bus_arb: two-requester round-robin arbiter driving a bidirectional bus buffer.
//
// A transfer is GRANT (1 cycle, bus turnaround), then XFER (WAIT_CYC
// cycles), then ACK (1 cycle). It always passes through IDLE between
// transfers. The winner's direction and write data are latched when the
// request is taken, so later changes on req/we/wdata do not affect a
// transfer that is already running. Every output is a register.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   req[1:0]   transfer request (bit 0 = CPU, bit 1 = DMA)
//   we[1:0]    per-requester direction, 1 = write
//   wdata0/1   write data from requester 0/1
//   bus_rdata  read data from the buffer's bus side
//   buf_en     buffer drive enable, 1 = drive the bus outward
//   bus_wdata  data presented to the buffer input
//   gnt[1:0]   one-hot owner of the current transfer
//   ack[1:0]   one-cycle completion pulse to the owner
//   rdata      captured read data, valid while ack is high
//   busy       high in every state except IDLE
module bus_arb #(
    parameter int WAIT_CYC = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] we,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    input  logic [7:0] bus_rdata,
    output logic       buf_en,
    output logic [7:0] bus_wdata,
    output logic [1:0] gnt,
    output logic [1:0] ack,
    output logic [7:0] rdata,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, GRANT, XFER, ACK} state_t;

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       last;              // requester served most recently
    logic       own, own_nxt;      // owner of the current transfer
    logic       we_l, we_nxt;
    logic [7:0] wd_l, wd_nxt;
    logic       win;

    // DMA wins when it asks alone, or when both ask and the CPU was served last.
    assign win = req[1] & (~req[0] | ~last);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        own_nxt   = own;
        we_nxt    = we_l;
        wd_nxt    = wd_l;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt = GRANT;
                    own_nxt   = win;
                    we_nxt    = we[win];
                    wd_nxt    = win ? wdata1 : wdata0;
                end
            end
            GRANT: begin
                state_nxt = XFER;
                cnt_nxt   = 4'(WAIT_CYC - 1);
            end
            XFER: begin
                if (cnt == 4'd0) state_nxt = ACK;
                else             cnt_nxt   = cnt - 4'd1;
            end
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            last      <= 1'b1;      // makes requester 0 win the first contention
            own       <= 1'b0;
            we_l      <= 1'b0;
            wd_l      <= 8'h00;
            gnt       <= 2'b00;
            ack       <= 2'b00;
            buf_en    <= 1'b0;
            bus_wdata <= 8'h00;
            rdata     <= 8'h00;
            busy      <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            own   <= own_nxt;
            we_l  <= we_nxt;
            wd_l  <= wd_nxt;
            if (state == ACK) last <= own;
            // Capture read data on the edge that ends the final XFER cycle.
            if (state == XFER && cnt == 4'd0 && !we_l) rdata <= bus_rdata;

            // Outputs are registered from the next state so they line up
            // with the state they describe.
            busy      <= (state_nxt != IDLE);
            gnt       <= (state_nxt == IDLE) ? 2'b00 : (own_nxt ? 2'b10 : 2'b01);
            ack       <= (state_nxt == ACK) ? (own_nxt ? 2'b10 : 2'b01) : 2'b00;
            buf_en    <= (state_nxt == XFER) && we_nxt;
            bus_wdata <= ((state_nxt == XFER) && we_nxt) ? wd_nxt : 8'h00;
        end
    end

endmodule

// File: tb/tb_bus_arb.sv
// Bench for bus_arb: two instances (WAIT_CYC = 1 and 3) share the same
// stimulus. A transaction-level model (busy flag + position within the
// transfer) predicts every output each cycle; directed sequences pin the
// model with hand-computed values.
module tb_bus_arb;
    logic       clk, rst;
    logic [1:0] req, we;
    logic [7:0] wdata0, wdata1, bus_rdata;

    logic       be [2];
    logic [7:0] bw [2];
    logic [1:0] g  [2];
    logic [1:0] a  [2];
    logic [7:0] rd [2];
    logic       bz [2];

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 0;

    bus_arb #(.WAIT_CYC(1)) dut_a (
        .clk(clk), .rst(rst), .req(req), .we(we), .wdata0(wdata0), .wdata1(wdata1),
        .bus_rdata(bus_rdata), .buf_en(be[0]), .bus_wdata(bw[0]), .gnt(g[0]),
        .ack(a[0]), .rdata(rd[0]), .busy(bz[0]));

    bus_arb #(.WAIT_CYC(3)) dut_b (
        .clk(clk), .rst(rst), .req(req), .we(we), .wdata0(wdata0), .wdata1(wdata1),
        .bus_rdata(bus_rdata), .buf_en(be[1]), .bus_wdata(bw[1]), .gnt(g[1]),
        .ack(a[1]), .rdata(rd[1]), .busy(bz[1]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst=%0d t=%0t actual=%h required=%h", nm, inst, $time, act, exp);
        end
    endtask

    function automatic int wc(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    // ---------------- behavioural model ----------------
    // m_t: 0 = grant cycle, 1..W = data phase, W+1 = completion cycle.
    int         m_busy [2];
    int         m_t    [2];
    int         m_own  [2];
    int         m_we   [2];
    int         m_last [2];
    logic [7:0] m_wd   [2];
    logic [7:0] m_rd   [2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_busy[i] = 0; m_t[i] = 0; m_own[i] = 0; m_we[i] = 0;
                m_last[i] = 1; m_wd[i] = 8'h00; m_rd[i] = 8'h00;
            end else if (m_busy[i] == 0) begin
                if (req != 2'b00) begin
                    if (req == 2'b01)      m_own[i] = 0;
                    else if (req == 2'b10) m_own[i] = 1;
                    else                   m_own[i] = 1 - m_last[i];
                    m_we[i]   = int'(we[m_own[i]]);
                    m_wd[i]   = (m_own[i] == 1) ? wdata1 : wdata0;
                    m_busy[i] = 1;
                    m_t[i]    = 0;
                end
            end else if (m_t[i] == wc(i) + 1) begin
                m_busy[i] = 0;
                m_last[i] = m_own[i];
            end else begin
                if (m_t[i] == wc(i) && m_we[i] == 0) m_rd[i] = bus_rdata;
                m_t[i]++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                logic [1:0] oh;
                logic       xe;
                oh = (m_own[i] == 1) ? 2'b10 : 2'b01;
                xe = (m_busy[i] != 0) && m_t[i] >= 1 && m_t[i] <= wc(i) && m_we[i] != 0;
                chk("gnt",       i, g[i],  (m_busy[i] != 0) ? oh : 2'b00);
                chk("ack",       i, a[i],  (m_busy[i] != 0 && m_t[i] == wc(i) + 1) ? oh : 2'b00);
                chk("busy",      i, bz[i], (m_busy[i] != 0));
                chk("buf_en",    i, be[i], xe);
                chk("bus_wdata", i, bw[i], xe ? m_wd[i] : 8'h00);
                chk("rdata",     i, rd[i], m_rd[i]);
                chk("gnt_onehot", i, ($countones(g[i]) <= 1), 1);
                chk("ack_onehot", i, ($countones(a[i]) <= 1), 1);
                chk("ack_in_gnt", i, ((a[i] & ~g[i]) == 2'b00), 1);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; req = 2'b00; we = 2'b00;
        wdata0 = 8'h00; wdata1 = 8'h00; bus_rdata = 8'h00;
        cyc(2);
        chk("rst_gnt", 0, g[0], 2'b00);
        chk("rst_busy", 0, bz[0], 1'b0);
        chk("rst_buf_en", 0, be[0], 1'b0);
        chk("rst_bus_wdata", 0, bw[0], 8'h00);
        chk("rst_rdata", 0, rd[0], 8'h00);
        chk("rst_ack", 1, a[1], 2'b00);
        rst = 1'b0;
        chk_en = 1;
        cyc(1);

        // Single write on CPU, wdata changes after latching are ignored.
        req = 2'b01; we = 2'b01; wdata0 = 8'h6D;
        cyc(1);
        chk("w_gnt", 0, g[0], 2'b01);
        req = 2'b00; we = 2'b00; wdata0 = 8'h11;
        cyc(1);
        chk("w_buf_en", 0, be[0], 1'b1);
        chk("w_bus_wdata", 0, bw[0], 8'h6D);
        cyc(1);
        chk("w_ack", 0, a[0], 2'b01);
        chk("w_buf_en_off", 0, be[0], 1'b0);
        cyc(8);

        // Single read on DMA.
        req = 2'b10; we = 2'b00; bus_rdata = 8'hA5;
        cyc(1);
        chk("r_gnt", 0, g[0], 2'b10);
        req = 2'b00;
        cyc(1);
        chk("r_buf_en", 0, be[0], 1'b0);
        cyc(1);
        chk("r_ack", 0, a[0], 2'b10);
        chk("r_rdata", 0, rd[0], 8'hA5);
        cyc(2);
        chk("r_ack", 1, a[1], 2'b10);
        chk("r_rdata", 1, rd[1], 8'hA5);
        cyc(6);

        // DMA write on the WAIT_CYC=3 instance: three data cycles, ack at +5.
        req = 2'b10; we = 2'b10; wdata1 = 8'hFF;
        for (int k = 1; k <= 6; k++) begin
            cyc(1);
            if (k == 1) req = 2'b00;
            chk("w3_buf_en", 1, be[1], (k >= 2 && k <= 4));
            chk("w3_ack", 1, a[1], (k == 5) ? 2'b10 : 2'b00);
        end
        cyc(6);

        // Contention after reset: CPU first, then strict alternation.
        rst = 1'b1;
        cyc(1);
        rst = 1'b0; req = 2'b11; we = 2'b00;
        for (int k = 1; k <= 16; k++) begin
            logic [1:0] e;
            cyc(1);
            e = 2'b00;
            if (k == 3 || k == 11) e = 2'b01;
            if (k == 7 || k == 15) e = 2'b10;
            chk("rr_ack", 0, a[0], e);
        end
        req = 2'b00;
        cyc(8);

        // Reset in the middle of a transfer aborts it without an ack.
        req = 2'b01; we = 2'b01; wdata0 = 8'h3C;
        cyc(1);
        req = 2'b00;
        cyc(1);
        chk("ab_buf_en", 0, be[0], 1'b1);
        rst = 1'b1;
        cyc(1);
        chk("ab_ack", 0, a[0], 2'b00);
        chk("ab_gnt", 0, g[0], 2'b00);
        chk("ab_busy", 0, bz[0], 1'b0);
        chk("ab_buf_en_off", 0, be[0], 1'b0);
        rst = 1'b0; req = 2'b01; we = 2'b00;
        cyc(1);
        chk("ab_regnt", 0, g[0], 2'b01);
        req = 2'b00;
        cyc(2);
        chk("ab_reack", 0, a[0], 2'b01);
        cyc(6);

        // Random traffic with occasional resets.
        for (int k = 0; k < 3000; k++) begin
            rst       = ($urandom_range(0, 199) == 0);
            req       = 2'($urandom);
            we        = 2'($urandom);
            wdata0    = 8'($urandom);
            wdata1    = 8'($urandom);
            bus_rdata = 8'($urandom);
            cyc(1);
        end
        rst = 1'b0; req = 2'b00;
        cyc(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/bus_arb.md
BUS_ARB -- requirements
Module: bus_arb

Interface
REQ-001 Parameter WAIT_CYC, default 1: number of data-phase cycles per transfer; legal range 1..15.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req  input  2  transfer request per requester; bit 0 = CPU, bit 1 = DMA.
REQ-005 we  input  2  per-requester direction; 1 = write (drive bus), 0 = read.
REQ-006 wdata0  input  8  write data from requester 0.
REQ-007 wdata1  input  8  write data from requester 1.
REQ-008 bus_rdata  input  8  data returned from the bidirectional buffer's bus side.
REQ-009 buf_en  output  1  direction/enable to the bidirectional buffer; 1 = drive bus outward.
REQ-010 bus_wdata  output  8  data presented to the buffer input.
REQ-011 gnt  output  2  one-hot grant; owner of the current transfer.
REQ-012 ack  output  2  one-cycle completion pulse to the winning requester.
REQ-013 rdata  output  8  captured read data; valid in the cycle ack is high.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 FSM states IDLE, GRANT, XFER, ACK; all outputs registered.
REQ-016 IDLE: no req -> stay; any req bit set -> select winner, latch winner's we and wdata, go to GRANT.
REQ-017 Arbitration: round-robin; single requester always wins; both requesting -> the requester not served last wins; after reset, requester 0 has priority.
REQ-018 GRANT: exactly one cycle; gnt = winner one-hot; buf_en = 0 (bus turnaround cycle); next XFER.
REQ-019 XFER: lasts exactly WAIT_CYC cycles (4-bit down-counter); buf_en = latched we; bus_wdata = latched wdata on write, 8'h00 on read.
REQ-020 Read: bus_rdata sampled into rdata on the final XFER cycle; write: rdata holds its previous value.
REQ-021 ACK: one cycle; ack[winner] = 1; gnt held; buf_en = 0; last-served pointer updated; next IDLE.
REQ-022 Latency: req sampled high in IDLE at edge N -> GRANT at N+1, XFER N+2..N+1+WAIT_CYC, ack at N+2+WAIT_CYC.
REQ-023 Back-to-back: minimum one IDLE cycle between ACK and the next GRANT; a req still high after ack is treated as a new request.
REQ-024 req deassertion, or changes to we/wdata, after latching in IDLE shall be ignored; the transfer completes.
REQ-025 buf_en shall never be 1 outside XFER, and never 1 for a read transfer.
REQ-026 gnt is zero in IDLE; ack is never asserted to a requester that is not the granted one; ack and gnt never have more than one bit set.

Reset
REQ-027 On rst at any clock edge, including mid-transfer: state = IDLE, gnt = 0, ack = 0, buf_en = 0, bus_wdata = 8'h00, rdata = 8'h00, busy = 0, counter = 0, priority to requester 0.
REQ-028 An aborted transfer shall produce no ack; rst has precedence over all other inputs.

Verification
REQ-029 Single write, WAIT_CYC=1: req=01, we=01, wdata0=8'h6D -> gnt=01 at N+1, buf_en=1 and bus_wdata=8'h6D at N+2, ack=01 at N+3, buf_en=0 at N+3.
REQ-030 Single read: req=10, we=00, bus_rdata=8'hA5 -> buf_en stays 0 throughout, ack=10 and rdata=8'hA5 at N+3.
REQ-031 Contention: req=11 held continuously -> grants alternate 01,10,01,10 with ack pulses separated by 4 cycles; no starvation.
REQ-032 WAIT_CYC=3, write wdata1=8'hFF -> buf_en high for exactly 3 consecutive cycles; ack 5 cycles after the request is sampled.
REQ-033 rst asserted during XFER -> next cycle all outputs at reset values, no ack issued; following req=01 is served by the normal sequence.
REQ-034 Assertion check over random traffic: buf_en never high during a read or outside XFER; gnt and ack always one-hot or zero.
